// File: rtl/video_ddr_wr_arbiter_if.sv
// video_ddr_wr_arbiter_if
//   Bundles the sampler-side burst request / FIFO read signals and the
//   AXI-style DDR write address and data channels used by the arbiter.
//   master : arbiter side (drives pops and the AXI write port)
//   slave  : environment side (samplers plus DDR controller)
// Signals
//   ch_ready, ch_id, ch_rd_data, ch_frame_start : per-channel sampler inputs
//   ch_rd_en                                    : per-channel FIFO pop
//   axi_aw*                                     : write address channel
//   axi_w*                                      : write data channel
//   busy                                        : arbiter not idle
interface video_ddr_wr_arbiter_if #(
  parameter int CH_NUM     = 4,
  parameter int DQ_WIDTH   = 32,
  parameter int ADDR_WIDTH = 28
);
  logic [CH_NUM-1:0]            ch_ready;
  logic [4*CH_NUM-1:0]          ch_id;
  logic [DQ_WIDTH*8*CH_NUM-1:0] ch_rd_data;
  logic [CH_NUM-1:0]            ch_frame_start;
  logic [CH_NUM-1:0]            ch_rd_en;
  logic [ADDR_WIDTH-1:0]        axi_awaddr;
  logic [3:0]                   axi_awid;
  logic [7:0]                   axi_awlen;
  logic                         axi_awvalid;
  logic                         axi_awready;
  logic [DQ_WIDTH*8-1:0]        axi_wdata;
  logic                         axi_wvalid;
  logic                         axi_wlast;
  logic                         axi_wready;
  logic                         busy;

  modport master (
    input  ch_ready, ch_id, ch_rd_data, ch_frame_start, axi_awready, axi_wready,
    output ch_rd_en, axi_awaddr, axi_awid, axi_awlen, axi_awvalid,
           axi_wdata, axi_wvalid, axi_wlast, busy
  );

  modport slave (
    output ch_ready, ch_id, ch_rd_data, ch_frame_start, axi_awready, axi_wready,
    input  ch_rd_en, axi_awaddr, axi_awid, axi_awlen, axi_awvalid,
           axi_wdata, axi_wvalid, axi_wlast, busy
  );
endinterface

// File: rtl/video_ddr_wr_arbiter.sv
// video_ddr_wr_arbiter
//   Round-robin arbiter between CH_NUM video sampler channels. Each grant
//   drains BURST_LEN beats from the granted channel's FWFT FIFO onto an
//   AXI-style DDR write port. A write pointer per channel walks through that
//   channel's frame region and is rewound on frame start or at region end.
// Ports
//   clk_i : single clock
//   rst_i : synchronous active-high reset
//   bus   : video_ddr_wr_arbiter_if.master (sampler side + AXI write side)
module video_ddr_wr_arbiter #(
  parameter int CH_NUM       = 4,
  parameter int DQ_WIDTH     = 32,
  parameter int ADDR_WIDTH   = 28,
  parameter int BURST_LEN    = 8,
  parameter int REGION_BEATS = 3600
) (
  input logic                     clk_i,
  input logic                     rst_i,
  video_ddr_wr_arbiter_if.master  bus
);

  localparam int GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int PW = $clog2(REGION_BEATS);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int DW = DQ_WIDTH * 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state_q;
  logic [GW-1:0]         grant_q;
  logic [GW-1:0]         last_grant_q;
  logic [GW-1:0]         grant_d;
  logic                  grant_vld_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ADDR_WIDTH-1:0] awaddr_d;
  logic [3:0]            awid_q;
  logic                  awvalid_q;
  logic [BW-1:0]         beat_cnt_q;
  logic [PW-1:0]         ptr_q [CH_NUM];
  logic [CH_NUM-1:0]     pending_clr_q;
  logic                  beat_fire;
  logic                  burst_done;

  // Round-robin search starting just after the last served channel, so the
  // channel that just finished has the lowest priority next time.
  always_comb begin
    int idx;
    grant_d     = '0;
    grant_vld_d = 1'b0;
    idx         = 0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = (int'(last_grant_q) + i) % CH_NUM;
      if (!grant_vld_d && bus.ch_ready[idx]) begin
        grant_vld_d = 1'b1;
        grant_d     = GW'(idx);
      end
    end
  end

  // Byte address of the next burst; kept in ADDR_WIDTH bits so an oversized
  // region layout wraps instead of growing the datapath.
  assign awaddr_d = (ADDR_WIDTH'(grant_d) * ADDR_WIDTH'(REGION_BEATS)
                     + ADDR_WIDTH'(ptr_q[grant_d])) * ADDR_WIDTH'(DQ_WIDTH);

  assign beat_fire  = (state_q == DATA) && bus.axi_wready;
  assign burst_done = beat_fire && (beat_cnt_q == BW'(BURST_LEN - 1));

  assign bus.axi_awaddr  = awaddr_q;
  assign bus.axi_awid    = awid_q;
  assign bus.axi_awlen   = 8'(BURST_LEN - 1);
  assign bus.axi_awvalid = awvalid_q;
  assign bus.axi_wvalid  = (state_q == DATA);
  assign bus.axi_wlast   = (state_q == DATA) && (beat_cnt_q == BW'(BURST_LEN - 1));
  assign bus.busy        = (state_q != IDLE);

  // The FIFO head is forwarded directly; it is forced to zero outside DATA
  // so the write bus is quiet while idle or in reset.
  assign bus.axi_wdata = (state_q == DATA) ? bus.ch_rd_data[int'(grant_q)*DW +: DW] : '0;

  // A pop happens exactly when a beat is accepted, so the FWFT head advances
  // in lockstep with the AXI data handshake.
  always_comb begin
    bus.ch_rd_en = '0;
    if (beat_fire) begin
      bus.ch_rd_en[grant_q] = 1'b1;
    end
  end

  // Arbiter FSM with its pointer bookkeeping. Frame starts are handled first;
  // the burst-end pointer update comes later in the block so it takes
  // precedence for the granted channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= GW'(CH_NUM - 1);
      awaddr_q      <= '0;
      awid_q        <= '0;
      awvalid_q     <= 1'b0;
      beat_cnt_q    <= '0;
      pending_clr_q <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        ptr_q[k] <= '0;
      end
    end else begin
      // A channel whose burst is in flight keeps its latched address and
      // only remembers to rewind once that burst ends.
      for (int k = 0; k < CH_NUM; k++) begin
        if (bus.ch_frame_start[k]) begin
          if ((state_q != IDLE) && (grant_q == GW'(k))) begin
            pending_clr_q[k] <= 1'b1;
          end else begin
            ptr_q[k] <= '0;
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            grant_q   <= grant_d;
            awid_q    <= bus.ch_id[int'(grant_d)*4 +: 4];
            awaddr_q  <= awaddr_d;
            awvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (bus.axi_awready) begin
            awvalid_q  <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q + BW'(1);
          end
          if (burst_done) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
            if (pending_clr_q[grant_q] || bus.ch_frame_start[grant_q]) begin
              ptr_q[grant_q]         <= '0;
              pending_clr_q[grant_q] <= 1'b0;
            end else if (int'(ptr_q[grant_q]) + BURST_LEN >= REGION_BEATS) begin
              ptr_q[grant_q] <= '0;
            end else begin
              ptr_q[grant_q] <= ptr_q[grant_q] + PW'(BURST_LEN);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_ddr_wr_arbiter.sv
// tb_video_ddr_wr_arbiter
//   Directed bench for video_ddr_wr_arbiter with default parameters.
//   Each sampler FIFO is modelled as a counter: the head word of channel k
//   is {k, number of pops since reset}.
module tb_video_ddr_wr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] popCnt [4];

  always #5 clk = ~clk;

  video_ddr_wr_arbiter_if bus ();

  video_ddr_wr_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // FIFO model: head advances on each pop
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) popCnt[k] <= '0;
      else if (bus.ch_rd_en[k]) popCnt[k] <= popCnt[k] + 16'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    assign bus.ch_rd_data[g*256 +: 256] = {232'd0, 8'(g), popCnt[g]};
  end

  task automatic doReset();
    rst                = 1'b1;
    bus.ch_ready       = '0;
    bus.ch_frame_start = '0;
    bus.axi_awready    = 1'b1;
    bus.axi_wready     = 1'b1;
    bus.ch_id          = 16'hFA51;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Follows one burst with awready/wready high; optionally pulses the
  // granted channel's frame_start right after beat pulseBeat is seen.
  task automatic runBurst(input int pulseBeat, output bit ok,
                          output logic [27:0] addr, output logic [3:0] id,
                          output int ch, output int pops, output int lastPos,
                          output int dataBad);
    ok = 1'b0; addr = '0; id = '0; ch = -1; pops = 0; lastPos = -1; dataBad = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.axi_awvalid === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    addr = bus.axi_awaddr;
    id   = bus.axi_awid;
    ok   = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      bus.ch_frame_start = '0;
      if (bus.axi_wvalid === 1'b1 && bus.axi_wready) begin
        if ($onehot(bus.ch_rd_en)) begin
          for (int k = 0; k < 4; k++) if (bus.ch_rd_en[k]) ch = k;
          pops++;
          if (bus.axi_wdata !== {232'd0, 8'(ch), popCnt[ch]}) dataBad++;
        end else begin
          dataBad++;
        end
        if (pulseBeat >= 0 && pulseBeat == pops - 1 && ch >= 0)
          bus.ch_frame_start[ch] = 1'b1;
        if (bus.axi_wlast === 1'b1) begin lastPos = pops; ok = 1'b1; break; end
      end
    end
    bus.ch_frame_start = '0;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast, bus.busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000",
               {bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast, bus.busy});
    end
    checks++;
    if (bus.ch_rd_en !== 4'd0 || bus.axi_awaddr !== 28'd0 || bus.axi_awid !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_bus: rd_en=%b awaddr=%0d awid=%0d expected all 0",
               bus.ch_rd_en, bus.axi_awaddr, bus.axi_awid);
    end
    checks++;
    if (bus.axi_wdata !== 256'd0) begin
      errors++;
      $display("[TB] FAIL reset_wdata: got %h expected 0", bus.axi_wdata);
    end
    checks++;
    if (bus.axi_awlen !== 8'd7) begin
      errors++;
      $display("[TB] FAIL reset_awlen: got %0d expected 7", bus.axi_awlen);
    end
  endtask

  task automatic test_single();
    bit ok; logic [27:0] addr; logic [3:0] id; int ch, pops, lastPos, dataBad;
    doReset();
    bus.ch_ready = 4'b0001;
    runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
    checks++;
    if (!ok || addr !== 28'd0 || id !== 4'd1 || ch != 0) begin
      errors++;
      $display("[TB] FAIL t1_first: ok=%0d addr=%0d id=%0d ch=%0d expected ok=1 addr=0 id=1 ch=0",
               ok, addr, id, ch);
    end
    checks++;
    if (pops != 8 || lastPos != 8 || dataBad != 0) begin
      errors++;
      $display("[TB] FAIL t1_beats: pops=%0d wlast_at=%0d bad=%0d expected 8 8 0",
               pops, lastPos, dataBad);
    end
    runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
    bus.ch_ready = '0;
    checks++;
    if (!ok || addr !== 28'd256 || pops != 8 || dataBad != 0) begin
      errors++;
      $display("[TB] FAIL t1_second: ok=%0d addr=%0d pops=%0d bad=%0d expected 1 256 8 0",
               ok, addr, pops, dataBad);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t1_idle: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_round_robin();
    bit ok; logic [27:0] addr; logic [3:0] id; int ch, pops, lastPos, dataBad;
    int          expCh   [5] = '{0, 1, 2, 3, 0};
    logic [27:0] expAddr [5] = '{28'd0, 28'd115200, 28'd230400, 28'd345600, 28'd256};
    logic [3:0]  expId   [5] = '{4'h1, 4'h5, 4'hA, 4'hF, 4'h1};
    doReset();
    bus.ch_ready = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
      checks++;
      if (!ok || ch != expCh[n] || addr !== expAddr[n] || id !== expId[n] || pops != 8) begin
        errors++;
        $display("[TB] FAIL t2_grant%0d: ok=%0d ch=%0d addr=%0d id=%0d pops=%0d expected ch=%0d addr=%0d id=%0d pops=8",
                 n, ok, ch, addr, id, pops, expCh[n], expAddr[n], expId[n]);
      end
    end
    bus.ch_ready = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok; int pops, stallLeft; bit stalled;
    logic [255:0] expHold;
    doReset();
    bus.ch_ready = 4'b0001;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.axi_awvalid === 1'b1) begin ok = 1'b1; break; end
    end
    bus.ch_ready = '0;
    pops = 0; stallLeft = 0; stalled = 1'b0;
    expHold = {232'd0, 8'd0, 16'd2};
    if (ok) begin
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (!stalled && pops == 2) begin
          bus.axi_wready = 1'b0; stalled = 1'b1; stallLeft = 3;
        end
        if (stallLeft > 0) begin
          #1;
          checks++;
          if (bus.ch_rd_en !== 4'd0 || bus.axi_wdata !== expHold || bus.axi_wvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL t3_stall%0d: rd_en=%b wvalid=%b wdata=%h expected 0 1 %h",
                     stallLeft, bus.ch_rd_en, bus.axi_wvalid, bus.axi_wdata, expHold);
          end
          stallLeft--;
          continue;
        end
        bus.axi_wready = 1'b1;
        #1;
        if (bus.axi_wvalid === 1'b1 && bus.ch_rd_en === 4'b0001) pops++;
        if (bus.axi_wvalid === 1'b1 && bus.axi_wlast === 1'b1) begin ok = 1'b1; break; end
      end
    end
    bus.axi_wready = 1'b1;
    checks++;
    if (!ok || pops != 8 || !stalled) begin
      errors++;
      $display("[TB] FAIL t3_pops: ok=%0d pops=%0d stalled=%0d expected 1 8 1", ok, pops, stalled);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok; logic [27:0] addr; logic [3:0] id; int ch, pops, lastPos, dataBad;
    bit allOk;
    doReset();
    bus.ch_ready = 4'b0100;
    allOk = 1'b1;
    for (int n = 0; n < 449; n++) begin
      runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
      if (!ok || ch != 2) begin allOk = 1'b0; break; end
    end
    checks++;
    if (!allOk || addr !== 28'd345088) begin
      errors++;
      $display("[TB] FAIL t4_preload: ok=%0d addr=%0d expected 1 345088", allOk, addr);
    end
    runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
    checks++;
    if (!ok || addr !== 28'd345344 || id !== 4'hA) begin
      errors++;
      $display("[TB] FAIL t4_end: ok=%0d addr=%0d id=%0d expected 1 345344 10", ok, addr, id);
    end
    runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
    bus.ch_ready = '0;
    checks++;
    if (!ok || addr !== 28'd230400) begin
      errors++;
      $display("[TB] FAIL t4_wrap: ok=%0d addr=%0d expected 1 230400", ok, addr);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_start();
    bit ok; logic [27:0] addr; logic [3:0] id; int ch, pops, lastPos, dataBad;
    doReset();
    bus.ch_ready = 4'b0001;
    runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
    runBurst(3, ok, addr, id, ch, pops, lastPos, dataBad);
    checks++;
    if (!ok || addr !== 28'd256 || pops != 8) begin
      errors++;
      $display("[TB] FAIL t5_inflight: ok=%0d addr=%0d pops=%0d expected 1 256 8", ok, addr, pops);
    end
    runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
    checks++;
    if (!ok || addr !== 28'd0) begin
      errors++;
      $display("[TB] FAIL t5_rewind: ok=%0d addr=%0d expected 1 0", ok, addr);
    end
    runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
    bus.ch_ready = '0;
    checks++;
    if (!ok || addr !== 28'd256) begin
      errors++;
      $display("[TB] FAIL t5_after: ok=%0d addr=%0d expected 1 256", ok, addr);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok; logic [27:0] addr; logic [3:0] id; int ch, pops, lastPos, dataBad;
    doReset();
    bus.ch_ready = 4'b1111;
    runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.axi_awvalid === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || bus.axi_awaddr !== 28'd115200) begin
      errors++;
      $display("[TB] FAIL t6_ch1: ok=%0d addr=%0d expected 1 115200", ok, bus.axi_awaddr);
    end
    pops = 0; ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.axi_wvalid === 1'b1) begin
        if (pops == 4) begin rst = 1'b1; ok = 1'b1; break; end
        pops++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (!ok || {bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast, bus.busy} !== 4'b0000 ||
        bus.ch_rd_en !== 4'd0 || bus.axi_awaddr !== 28'd0 || bus.axi_awid !== 4'd0 ||
        bus.axi_wdata !== 256'd0) begin
      errors++;
      $display("[TB] FAIL t6_cleared: ok=%0d ctrl=%b rd_en=%b awaddr=%0d awid=%0d expected all 0",
               ok, {bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast, bus.busy},
               bus.ch_rd_en, bus.axi_awaddr, bus.axi_awid);
    end
    runBurst(-1, ok, addr, id, ch, pops, lastPos, dataBad);
    bus.ch_ready = '0;
    checks++;
    if (!ok || ch != 0 || addr !== 28'd0 || id !== 4'd1 || pops != 8) begin
      errors++;
      $display("[TB] FAIL t6_restart: ok=%0d ch=%0d addr=%0d id=%0d pops=%0d expected 1 0 0 1 8",
               ok, ch, addr, id, pops);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst                = 1'b1;
    bus.ch_ready       = '0;
    bus.ch_frame_start = '0;
    bus.ch_id          = 16'hFA51;
    bus.axi_awready    = 1'b1;
    bus.axi_wready     = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap();
    test_frame_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
